fir_seq: RTL and testbench
==========================

FIR_SEQ -- requirements
Module: fir_seq

Interface
REQ-001 Parameter N_TAPS, default 16, number of filter taps; power of two, at least 2.
REQ-002 Parameter MAC_LAT, default 1, pipeline latency of the downstream MAC in cycles; range 0..7.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 clr  in  1  reset, asynchronous, active-high.
REQ-005 in_valid  in  1  new sample present on the shift-register data input; held stable until accepted.
REQ-006 in_ready  out  1  sample accepted in this cycle (handshake in_valid & in_ready).
REQ-007 out_valid  out  1  MAC result valid.
REQ-008 out_ready  in  1  consumer takes the result.
REQ-009 asr_en  out  1  shift enable for the addressable shift register.
REQ-010 asr_add  out  $clog2(N_TAPS)  shift-register read address (0 = current input sample, k = sample n-k).
REQ-011 coef_add  out  $clog2(N_TAPS)  coefficient ROM address.
REQ-012 mac_en  out  1  MAC accumulates this cycle.
REQ-013 mac_clr  out  1  MAC loads the product instead of accumulating (first tap).
REQ-014 busy  out  1  state is not IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, MAC, DRAIN and OUT, and a tap counter tap ranging over 0..N_TAPS-1.
REQ-016 IDLE: if in_valid=1, go to MAC with tap=0; otherwise stay.
REQ-017 MAC: asr_add=coef_add=tap, mac_en=1, mac_clr=(tap==0), tap increments each cycle; lasts exactly N_TAPS cycles.
REQ-018 On the last MAC cycle (tap==N_TAPS-1), in_ready=1 and asr_en=1 in the same cycle, so the sample is shifted in after all taps have been read; next state is DRAIN, or OUT if MAC_LAT=0.
REQ-019 in_ready and asr_en SHALL be 0 in every other cycle; mac_en and mac_clr SHALL be 0 outside MAC.
REQ-020 DRAIN: lasts MAC_LAT cycles with all datapath controls at 0, then goes to OUT.
REQ-021 OUT: out_valid=1 until out_valid & out_ready; on that cycle, go to MAC with tap=0 if in_valid=1, else go to IDLE (no bubble).
REQ-022 Latency: first out_valid N_TAPS+MAC_LAT+1 cycles after the edge at which IDLE samples in_valid=1; back-to-back period is N_TAPS+MAC_LAT+1 cycles.
REQ-023 out_ready=0 SHALL hold OUT indefinitely with in_ready=0 and asr_en=0 (backpressure).
REQ-024 in_valid deasserted during MAC is a protocol violation; the sweep SHALL still complete unchanged.
REQ-025 asr_add and coef_add SHALL be 0 outside MAC.

Reset
REQ-026 clr=1 SHALL immediately force IDLE and tap=0; all outputs SHALL be 0, including in_ready and asr_en.
REQ-027 Reset during MAC or OUT SHALL drop the sample in progress without an asr_en pulse; the next accepted sample restarts at tap 0.

Configuration
REQ-028 Macro FIR_SEQ_CNT_EN defined: adds output smp_cnt [15:0], incremented on every in_valid & in_ready handshake, saturating at 0xFFFF, reset to 0 by clr.
REQ-029 Macro FIR_SEQ_CNT_EN undefined: port smp_cnt and its logic are absent; all other behaviour is identical.

Structure
REQ-030 Package fir_pkg SHALL hold the FSM state typedef (IDLE, MAC, DRAIN, OUT) and the default constants N_TAPS_DEF=16 and MAC_LAT_DEF=1.
REQ-031 The tap counter and the DRAIN counter SHALL each use one instance of sub-module fir_seq_cnt (modulo-N counter with clear, enable and terminal-count flag).

Verification (N_TAPS=16, MAC_LAT=1)
REQ-032 Reset: clr=1 with in_valid=1 -> all outputs 0 and busy=0 throughout reset.
REQ-033 Single sample, out_ready=1, in_valid seen at edge 0 -> asr_add 0..15 in cycles 1..16; mac_clr only in cycle 1; in_ready=asr_en=1 only in cycle 16; out_valid only in cycle 18.
REQ-034 Backpressure, out_ready=0 for 5 cycles after out_valid rises -> out_valid high for 6 cycles; in_ready and asr_en stay 0 throughout.
REQ-035 in_valid and out_ready held at 1 -> one out_valid every 18 cycles; MAC tap 0 in the cycle immediately after each output handshake.
REQ-036 clr pulse at tap 7 -> outputs 0 at once; no asr_en; the next sample sweeps from tap 0 with out_valid 18 cycles later.
REQ-037 With FIR_SEQ_CNT_EN: 3 samples -> smp_cnt=3; after a clr pulse, smp_cnt=0.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types and default constants for the fir_seq FIR sequencer.
package fir_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MAC   = 2'd1,
      DRAIN = 2'd2,
      OUT   = 2'd3
   } fir_state_e;

   localparam int N_TAPS_DEF  = 16;
   localparam int MAC_LAT_DEF = 1;

endpackage

// File: rtl/fir_seq_cnt.sv
// Modulo-MOD counter with synchronous clear, enable and terminal-count flag.
module fir_seq_cnt #(
   parameter int MOD = 16,
   parameter int W   = (MOD > 1) ? $clog2(MOD) : 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_clr,
   input  logic         i_en,
   output logic [W-1:0] o_cnt,
   output logic         o_tc
);

   localparam logic [W-1:0] LAST = W'(MOD - 1);

   logic [W-1:0] r_cnt;

   // count register, wraps to zero after LAST
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + W'(1);
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign o_cnt = r_cnt;
   assign o_tc  = (r_cnt == LAST);

endmodule

// File: rtl/fir_seq.sv
// Sequencer for a time-multiplexed FIR: sweeps N_TAPS taps through a MAC, waits
// MAC_LAT cycles, then presents the result. Define FIR_SEQ_CNT_EN to add smp_cnt.
module fir_seq
   import fir_pkg::*;
#(
   parameter int N_TAPS  = N_TAPS_DEF,
   parameter int MAC_LAT = MAC_LAT_DEF
) (
   input  logic                      clk,
   input  logic                      clr,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      asr_en,
   output logic [$clog2(N_TAPS)-1:0] asr_add,
   output logic [$clog2(N_TAPS)-1:0] coef_add,
   output logic                      mac_en,
   output logic                      mac_clr,
`ifdef FIR_SEQ_CNT_EN
   output logic [15:0]               smp_cnt,
`endif
   output logic                      busy
);

   localparam int AW   = $clog2(N_TAPS);
   localparam int DMOD = (MAC_LAT > 0) ? MAC_LAT : 1;
   localparam int DW   = (DMOD > 1) ? $clog2(DMOD) : 1;

   fir_state_e r_state;
   fir_state_e w_state_nxt;

   logic [AW-1:0] w_tap;
   logic          w_tap_tc;
   logic [DW-1:0] w_drn_cnt_unused;
   logic          w_drn_tc;

   fir_seq_cnt #(.MOD(N_TAPS), .W(AW)) u_tap_cnt (
      .clk   (clk),
      .rst   (clr),
      .i_clr (r_state != MAC),
      .i_en  (r_state == MAC),
      .o_cnt (w_tap),
      .o_tc  (w_tap_tc)
   );

   fir_seq_cnt #(.MOD(DMOD), .W(DW)) u_drn_cnt (
      .clk   (clk),
      .rst   (clr),
      .i_clr (r_state != DRAIN),
      .i_en  (r_state == DRAIN),
      .o_cnt (w_drn_cnt_unused),
      .o_tc  (w_drn_tc)
   );

   // state register
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // next-state and datapath control decode
   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      asr_en      = 1'b0;
      asr_add     = '0;
      coef_add    = '0;
      mac_en      = 1'b0;
      mac_clr     = 1'b0;
      out_valid   = 1'b0;
      case (r_state)
         IDLE: begin
            if (in_valid) begin
               w_state_nxt = MAC;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         MAC: begin
            mac_en   = 1'b1;
            mac_clr  = (w_tap == '0);
            asr_add  = w_tap;
            coef_add = w_tap;
            // the sample is shifted in only after the last tap has been read
            if (w_tap_tc) begin
               in_ready    = 1'b1;
               asr_en      = 1'b1;
               w_state_nxt = (MAC_LAT == 0) ? OUT : DRAIN;
            end else begin
               w_state_nxt = MAC;
            end
         end
         DRAIN: begin
            if (w_drn_tc) begin
               w_state_nxt = OUT;
            end else begin
               w_state_nxt = DRAIN;
            end
         end
         OUT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_state_nxt = in_valid ? MAC : IDLE;
            end else begin
               w_state_nxt = OUT;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign busy = (r_state != IDLE);

`ifdef FIR_SEQ_CNT_EN
   logic [15:0] r_smp_cnt;

   // accepted-sample counter, saturating
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_smp_cnt <= 16'd0;
      end else if (in_valid && in_ready && (r_smp_cnt != 16'hFFFF)) begin
         r_smp_cnt <= r_smp_cnt + 16'd1;
      end else begin
         r_smp_cnt <= r_smp_cnt;
      end
   end

   assign smp_cnt = r_smp_cnt;
`endif

endmodule

// File: tb/tb_fir_seq.sv
// Self-checking bench for fir_seq (N_TAPS=16, MAC_LAT=1) against a cycle-age
// transaction model; directed timing scenarios followed by random handshakes.
module tb_fir_seq;

   localparam int N  = 16;
   localparam int L  = 1;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          clr;
   logic          in_valid;
   logic          in_ready;
   logic          out_valid;
   logic          out_ready;
   logic          asr_en;
   logic [AW-1:0] asr_add;
   logic [AW-1:0] coef_add;
   logic          mac_en;
   logic          mac_clr;
   logic          busy;
`ifdef FIR_SEQ_CNT_EN
   logic [15:0]   smp_cnt;
`endif

   fir_seq #(.N_TAPS(N), .MAC_LAT(L)) dut (
      .clk       (clk),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .asr_en    (asr_en),
      .asr_add   (asr_add),
      .coef_add  (coef_add),
      .mac_en    (mac_en),
      .mac_clr   (mac_clr),
`ifdef FIR_SEQ_CNT_EN
      .smp_cnt   (smp_cnt),
`endif
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   // model: m_age = cycles since the current sweep began (0 = idle)
   int m_age = 0;
   int m_cnt = 0;
   bit o_ov, o_mclr, o_rdy, o_asr, hs_last;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s obs=%0d exp=%0d at %0t", tag, obs, exp_v, $time);
      end
   endtask

   task automatic step(input bit v, input bit r, input bit c);
      bit e_mac, e_last, e_ov, e_busy;
      int e_tap;
      @(negedge clk);
      in_valid  = v;
      out_ready = r;
      clr       = c;
      #1;
      e_mac  = !c && (m_age >= 1) && (m_age <= N);
      e_tap  = e_mac ? m_age - 1 : 0;
      e_last = !c && (m_age == N);
      e_ov   = !c && (m_age >= N + L + 1);
      e_busy = !c && (m_age != 0);
      check_val("busy",      busy,      e_busy);
      check_val("asr_add",   asr_add,   e_tap);
      check_val("coef_add",  coef_add,  e_tap);
      check_val("mac_en",    mac_en,    e_mac);
      check_val("mac_clr",   mac_clr,   e_mac && (e_tap == 0));
      check_val("in_ready",  in_ready,  e_last);
      check_val("asr_en",    asr_en,    e_last);
      check_val("out_valid", out_valid, e_ov);
`ifdef FIR_SEQ_CNT_EN
      check_val("smp_cnt",   smp_cnt,   c ? 0 : m_cnt);
`endif
      o_ov = out_valid; o_mclr = mac_clr; o_rdy = in_ready; o_asr = asr_en;
      hs_last = e_last && v;
      @(posedge clk);
      if (c) begin
         m_age = 0;
         m_cnt = 0;
      end else if (m_age == 0) begin
         if (v) m_age = 1;
      end else if (m_age <= N + L) begin
         if ((m_age == N) && v && (m_cnt < 65535)) m_cnt++;
         m_age++;
      end else if (r) begin
         m_age = v ? 1 : 0;
      end
   endtask

   // one sample from idle; out_ready held low for the first bp cycles of out_valid
   task automatic run_one(input int bp, output int t_ov, output int t_mclr, output int t_rdy,
                          output int n_ov, output int n_rdy, output int n_rdy_ov);
      bit v, r;
      int ovs;
      t_ov = -1; t_mclr = -1; t_rdy = -1; n_ov = 0; n_rdy = 0; n_rdy_ov = 0;
      v = 1'b1; ovs = 0;
      for (int i = 0; i < 80; i++) begin
         r = (ovs >= bp);
         step(v, r, 1'b0);
         if (o_mclr && t_mclr < 0) t_mclr = i;
         if (o_rdy) begin
            n_rdy++;
            if (t_rdy < 0) t_rdy = i;
         end
         if (o_ov) begin
            if (t_ov < 0) t_ov = i;
            n_ov++;
            ovs++;
            if (o_rdy || o_asr) n_rdy_ov++;
         end
         v = v && !hs_last;
         if (o_ov && r) break;
      end
   endtask

   initial begin
      int t_ov, t_mclr, t_rdy, n_ov, n_rdy, n_rdy_ov, n_asr, prev_ov;
      bit v, hold, c;
      clr = 1'b1; in_valid = 1'b1; out_ready = 1'b0;

      // reset held with in_valid asserted
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0);

      // single sample, no backpressure
      run_one(0, t_ov, t_mclr, t_rdy, n_ov, n_rdy, n_rdy_ov);
      check_val("single_t_mclr", t_mclr, 1);
      check_val("single_t_rdy",  t_rdy,  16);
      check_val("single_t_ov",   t_ov,   N + L + 1);
      check_val("single_n_ov",   n_ov,   1);
      check_val("single_n_rdy",  n_rdy,  1);
      step(1'b0, 1'b1, 1'b0);

      // backpressure: out_ready low for 5 cycles after out_valid rises
      run_one(5, t_ov, t_mclr, t_rdy, n_ov, n_rdy, n_rdy_ov);
      check_val("bp_t_ov",     t_ov,     N + L + 1);
      check_val("bp_n_ov",     n_ov,     6);
      check_val("bp_rdy_in_ov", n_rdy_ov, 0);
      step(1'b0, 1'b1, 1'b0);

      // clr pulse at tap 7 drops the sample without an asr_en pulse
      n_asr = 0;
      for (int i = 0; i <= 8; i++) begin
         step(1'b1, 1'b1, i == 8);
         if (o_asr) n_asr++;
      end
      check_val("clr_n_asr", n_asr, 0);
      step(1'b0, 1'b1, 1'b0);
      run_one(0, t_ov, t_mclr, t_rdy, n_ov, n_rdy, n_rdy_ov);
      check_val("clr_restart_mclr", t_mclr, 1);
      check_val("clr_restart_t_ov", t_ov,   N + L + 1);
      step(1'b0, 1'b1, 1'b0);

      // back-to-back with in_valid and out_ready held high
      prev_ov = -1; n_ov = 0;
      for (int i = 0; i < 58; i++) begin
         step(1'b1, 1'b1, 1'b0);
         if (o_ov) begin
            n_ov++;
            if (prev_ov >= 0) check_val("b2b_period", i - prev_ov, N + L + 1);
            else check_val("b2b_first", i, N + L + 1);
            prev_ov = i;
         end
      end
      check_val("b2b_n_ov", n_ov, 3);
      step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b0);

`ifdef FIR_SEQ_CNT_EN
      for (int k = 0; k < 3; k++) begin
         run_one(0, t_ov, t_mclr, t_rdy, n_ov, n_rdy, n_rdy_ov);
         step(1'b0, 1'b1, 1'b0);
      end
      check_val("cnt_three", smp_cnt, 3);
      step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b0);
      check_val("cnt_after_clr", smp_cnt, 0);
`endif

      // random handshakes with occasional clr; in_valid held until accepted
      hold = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         c = ($urandom_range(0, 99) == 0);
         v = hold ? 1'b1 : bit'($urandom_range(0, 1));
         step(v, ($urandom_range(0, 3) != 0), c);
         hold = v && !hs_last && !c;
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
